// File: rtl/alu_req_arbiter.sv
// Two-port arbiter in front of a shared combinational 32-bit ALU.
// Grants one request per cycle and registers the ALU result into a valid/ready response slot.
module alu_req_arbiter #(
  parameter int TAG_W      = 4,
  parameter int FIXED_PRIO = 0
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_op1,
  input  logic [31:0]      req0_op2,
  input  logic [3:0]       req0_alu_op,
  input  logic [TAG_W-1:0] req0_tag,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_op1,
  input  logic [31:0]      req1_op2,
  input  logic [3:0]       req1_alu_op,
  input  logic [TAG_W-1:0] req1_tag,

  output logic [31:0]      alu_value1,
  output logic [31:0]      alu_value2,
  output logic [3:0]       alu_op,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,

  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_port,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [31:0]      rsp_result,
  output logic             rsp_zero
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } rsp_state_t;

  rsp_state_t       state;
  logic             last_grant;
  logic             can_issue;
  logic             grant_any;
  logic             grant_port;
  logic [TAG_W-1:0] grant_tag;

  assign rsp_valid = (state == FULL);

  // The slot can be refilled in the same cycle it drains, giving one op per cycle.
  assign can_issue = !rsp_valid || rsp_ready;

  always_comb begin
    grant_any  = 1'b0;
    grant_port = 1'b0;
    if (!rst && can_issue) begin
      if (req0_valid && req1_valid) begin
        grant_any  = 1'b1;
        grant_port = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
      end else if (req0_valid) begin
        grant_any  = 1'b1;
      end else if (req1_valid) begin
        grant_any  = 1'b1;
        grant_port = 1'b1;
      end
    end
  end

  assign req0_ready = grant_any && !grant_port;
  assign req1_ready = grant_any &&  grant_port;

  // Without a grant the ALU sees all-zero inputs so no X reaches it.
  always_comb begin
    alu_value1 = 32'd0;
    alu_value2 = 32'd0;
    alu_op     = 4'b0000;
    grant_tag  = '0;
    if (grant_any) begin
      if (grant_port) begin
        alu_value1 = req1_op1;
        alu_value2 = req1_op2;
        alu_op     = req1_alu_op;
        grant_tag  = req1_tag;
      end else begin
        alu_value1 = req0_op1;
        alu_value2 = req0_op2;
        alu_op     = req0_alu_op;
        grant_tag  = req0_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      last_grant <= 1'b1;
      rsp_port   <= 1'b0;
      rsp_tag    <= '0;
      rsp_result <= 32'd0;
      rsp_zero   <= 1'b0;
    end else if (grant_any) begin
      state      <= FULL;
      last_grant <= grant_port;
      rsp_port   <= grant_port;
      rsp_tag    <= grant_tag;
      rsp_result <= alu_result;
      rsp_zero   <= alu_zero;
    end else if (state == FULL && rsp_ready) begin
      state      <= EMPTY;
    end
  end

endmodule
